mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset inputs.
REQ-002 Parameter WIDTH, default 64, operand and result width in bits.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 Op  input  2  operation: 00 MUL (low WIDTH bits), 01 UMULH (unsigned high), 10 SMULH (signed high), 11 treated as MUL.
REQ-007 RegsRn  input  WIDTH  first operand, from register file read port 1.
REQ-008 RegsRm  input  WIDTH  second operand, from register file read port 2.
REQ-009 RdIn  input  5  destination register index.
REQ-010 DataWr  output  WIDTH  result, to the register file write data.
REQ-011 RdOut  output  5  captured destination index, to the register file write address.
REQ-012 RFWr  output  1  one-cycle write strobe to the register file.
REQ-013 Busy  output  1  high whenever the state is not IDLE.
REQ-014 Done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 In IDLE with Start=1 at edge N, the block SHALL capture RegsRn, RegsRm, Op and RdIn, clear the step counter and enter CALC; later input changes have no effect on the result.
REQ-017 For SMULH, the captured operands SHALL be stored as magnitudes, with a result-sign flag set to sign(Rn) XOR sign(Rm); for MUL and UMULH, the operands are unsigned.
REQ-018 CALC SHALL perform one radix-2 shift-add step per cycle on a 2*WIDTH-bit accumulator, for exactly WIDTH steps (edges N+1 .. N+WIDTH).
REQ-019 At edge N+WIDTH, the block SHALL register DataWr as follows and enter DONE: low half for MUL; high half for UMULH; for SMULH, the high half of the two's-complement-negated product when the sign flag is set.
REQ-020 In DONE (the cycle between edges N+WIDTH and N+WIDTH+1), Done SHALL be 1, and RFWr SHALL be 1 if and only if RdOut != 31 (XZR).
REQ-021 At edge N+WIDTH+1, the FSM SHALL return to IDLE; Done and RFWr SHALL be 0 in all other cycles.
REQ-022 Start SHALL be ignored while Busy=1, including in the DONE cycle; a new request is accepted on the first IDLE cycle.
REQ-023 DataWr and RdOut SHALL hold their last values until the next DONE.
REQ-024 Zero operands SHALL take the full latency; there is no early termination.
REQ-025 The step counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 On rst=1, the block SHALL immediately (asynchronously) return to IDLE, with Busy=0, Done=0, RFWr=0, DataWr=0, RdOut=0, accumulator and counter cleared.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation with no RFWr pulse; the block SHALL then accept Start on the first edge after reset is released.

Structure
REQ-028 Package mul_pkg SHALL hold: the state enum (IDLE, CALC, DONE), the Op encoding enum, localparam XZR = 5'd31, and the default WIDTH = 64.
REQ-029 The design SHALL be a single module with no sub-module; magnitude and negation are inline arithmetic.

Verification
REQ-030 MUL: Rn=3, Rm=5, RdIn=2, Start at edge N -> Done and RFWr high only in cycle N+64, DataWr=15, RdOut=2.
REQ-031 UMULH: Rn=0xFFFF_FFFF_FFFF_FFFF, Rm=2 -> DataWr=1; then MUL with the same operands -> DataWr=0xFFFF_FFFF_FFFF_FFFE.
REQ-032 SMULH: Rn=-1, Rm=1 -> DataWr=0xFFFF_FFFF_FFFF_FFFF; Rn=0x8000_0000_0000_0000, Rm=-1 -> DataWr=0.
REQ-033 Start pulsed at N+10 and in the DONE cycle -> ignored, exactly one Done; operands changed at N+1 -> result unaffected.
REQ-034 rst asserted at N+30 -> Busy=0 and DataWr=0 immediately, no RFWr; a new MUL 7*6 after release -> DataWr=42.
REQ-035 RdIn=31, MUL 4*4 -> Done=1, RFWr=0, DataWr=16.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 64;

  // Register index 31 is the zero register; writes to it are suppressed.
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Encoding 2'b11 is not a distinct operation; it behaves like MUL.
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_SMULH = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier: one partial product per cycle, WIDTH cycles
// per operation, writing the low half, unsigned high half or signed high half
// of the product back to the register file.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] RegsRn,
  input  logic [WIDTH-1:0] RegsRm,
  input  logic [4:0]       RdIn,
  output logic [WIDTH-1:0] DataWr,
  output logic [4:0]       RdOut,
  output logic             RFWr,
  output logic             Busy,
  output logic             Done
);

  // One extra bit so the counter reaches WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out one bit per step as product bits shift in.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           rd_q, rd_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [4:0]           rdout_q, rdout_d;
  logic                 done_q, done_d;
  logic                 rfwr_q, rfwr_d;

  logic                 is_smulh;
  logic [WIDTH:0]       sum_c;
  logic [WIDTH-1:0]     prod_hi, prod_lo, neg_hi;

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    data_d   = data_q;
    rdout_d  = rdout_q;
    done_d   = 1'b0;
    rfwr_d   = 1'b0;
    is_smulh = (op_e'(Op) == OP_SMULH);
    sum_c    = '0;
    prod_hi  = '0;
    prod_lo  = '0;
    neg_hi   = '0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          // Signed high multiply works on magnitudes; the sign is reapplied
          // at the end. The most negative value maps to 2^(WIDTH-1), which
          // is still correct as an unsigned magnitude.
          a_d     = (is_smulh && RegsRn[WIDTH-1]) ? (-RegsRn) : RegsRn;
          acc_d   = {{WIDTH{1'b0}},
                     ((is_smulh && RegsRm[WIDTH-1]) ? (-RegsRm) : RegsRm)};
          neg_d   = is_smulh & (RegsRn[WIDTH-1] ^ RegsRm[WIDTH-1]);
          op_d    = op_e'(Op);
          rd_d    = RdIn;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        sum_c = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        acc_d = {sum_c, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          prod_hi = acc_d[2*WIDTH-1:WIDTH];
          prod_lo = acc_d[WIDTH-1:0];
          // High half of the two's-complement negation: invert the high
          // half and carry in only when the low half is all zeros.
          neg_hi  = ~prod_hi + WIDTH'(prod_lo == '0);
          case (op_q)
            OP_UMULH: data_d = prod_hi;
            OP_SMULH: data_d = neg_q ? neg_hi : prod_hi;
            default:  data_d = prod_lo;
          endcase
          rdout_d = rd_q;
          done_d  = 1'b1;
          rfwr_d  = (rd_q != XZR);
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      data_q  <= '0;
      rdout_q <= '0;
      done_q  <= 1'b0;
      rfwr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      data_q  <= data_d;
      rdout_q <= rdout_d;
      done_q  <= done_d;
      rfwr_q  <= rfwr_d;
    end
  end

  assign DataWr = data_q;
  assign RdOut  = rdout_q;
  assign RFWr   = rfwr_q;
  assign Done   = done_q;
  assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit at the default 64-bit width.
module tb_mul_unit;

  localparam int W = 64;

  logic          clk;
  logic          rst;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  RegsRn;
  logic [W-1:0]  RegsRm;
  logic [4:0]    RdIn;
  logic [W-1:0]  DataWr;
  logic [4:0]    RdOut;
  logic          RFWr;
  logic          Busy;
  logic          Done;

  int checks   = 0;
  int failures = 0;

  mul_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .Op     (Op),
    .RegsRn (RegsRn),
    .RegsRm (RegsRm),
    .RdIn   (RdIn),
    .DataWr (DataWr),
    .RdOut  (RdOut),
    .RFWr   (RFWr),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation at the next edge (N) and check the exact timing of
  // the completion pulse at N+W together with the written result.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] rn, input logic [W-1:0] rm,
                        input logic [4:0] rd, input logic [W-1:0] exp_data,
                        input logic exp_rfwr);
    Op = op; RegsRn = rn; RegsRm = rm; RdIn = rd; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk({tag, "_busy"}, W'(Busy), W'(1));
    repeat (W - 1) @(posedge clk);
    #1;
    chk({tag, "_done_early"}, W'(Done), W'(0));
    @(posedge clk); #1;
    chk({tag, "_done"}, W'(Done), W'(1));
    chk({tag, "_rfwr"}, W'(RFWr), W'(exp_rfwr));
    chk({tag, "_data"}, DataWr, exp_data);
    chk({tag, "_rd"}, W'(RdOut), W'(rd));
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, W'(Done), W'(0));
    chk({tag, "_rfwr_clr"}, W'(RFWr), W'(0));
    chk({tag, "_idle"}, W'(Busy), W'(0));
  endtask

  int pulses;

  initial begin
    rst = 1'b1; Start = 1'b0; Op = 2'b00; RegsRn = '0; RegsRm = '0; RdIn = '0;
    #3;
    chk("rst_busy", W'(Busy), W'(0));
    chk("rst_done", W'(Done), W'(0));
    chk("rst_rfwr", W'(RFWr), W'(0));
    chk("rst_data", DataWr, W'(0));
    chk("rst_rd", W'(RdOut), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("mul_3x5", 2'b00, 64'd3, 64'd5, 5'd2, 64'd15, 1'b1);
    run_op("umulh_max_x2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'd1, 1'b1);
    run_op("mul_max_x2", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    run_op("smulh_m1x1", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("smulh_min_xm1", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           5'd5, 64'd0, 1'b1);
    run_op("smulh_m3x5", 2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("umulh_2p63x4", 2'b01, 64'h8000_0000_0000_0000, 64'd4, 5'd7, 64'd2, 1'b1);
    run_op("op3_6x7", 2'b11, 64'd6, 64'd7, 5'd8, 64'd42, 1'b1);

    // Start repeated mid-calculation and in the DONE cycle; operands changed
    // right after capture. Exactly one completion with the original result.
    Op = 2'b00; RegsRn = 64'd9; RegsRm = 64'd9; RdIn = 5'd9; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; RegsRn = 64'd1000; RegsRm = 64'd3; RdIn = 5'd1; Op = 2'b01;
    pulses = 0;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      if (Done) pulses++;
      if (i == 9) Start = 1'b1;
      if (i == 10) begin
        Start = 1'b0;
        chk("ign_busy_n10", W'(Busy), W'(1));
      end
      if (i == 64) begin
        chk("ign_data", DataWr, 64'd81);
        chk("ign_rd", W'(RdOut), W'(9));
        Start = 1'b1;
      end
      if (i == 65) Start = 1'b0;
    end
    chk("ign_one_done", W'(pulses), W'(1));
    chk("ign_idle", W'(Busy), W'(0));

    // Asynchronous reset in the middle of a calculation.
    Op = 2'b00; RegsRn = 64'd100; RegsRm = 64'd100; RdIn = 5'd10; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("abort_busy_pre", W'(Busy), W'(1));
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(Busy), W'(0));
    chk("abort_data", DataWr, W'(0));
    chk("abort_rd", W'(RdOut), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (Done || RFWr) pulses++;
    end
    chk("abort_no_write", W'(pulses), W'(0));
    run_op("post_rst_7x6", 2'b00, 64'd7, 64'd6, 5'd11, 64'd42, 1'b1);

    run_op("xzr_4x4", 2'b00, 64'd4, 64'd4, 5'd31, 64'd16, 1'b0);
    run_op("zero_0x5", 2'b00, 64'd0, 64'd5, 5'd12, 64'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
